krnl_stream_merge_rr: RTL and testbench

Parametrised N-channel stream merger with a beat budget. It sits between the per-port input streams and the AXI write-master FIFO inside a kernel. It round-robin arbitrates `NUM_CH` valid/ready input streams into one registered output stream. Once started by a `ctrl_start` pulse, it forwards exactly `ctrl_length` beats, then pulses `ctrl_done`. It can optionally tag each beat with its source channel index.

---
 rtl/krnl_stream_merge_rr.sv | 156 +++++++++++++++
 tb/tb_krnl_stream_merge_rr.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/krnl_stream_merge_rr.sv
// Round-robin merger of NUM_CH valid/ready streams into one registered output
// stream, forwarding a fixed beat budget per start and pulsing done at the end.
module krnl_stream_merge_rr #(
    parameter int NUM_CH     = 8,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 32,
    parameter int TAG_MODE   = 0
) (
    input  logic                         ap_aclk,
    input  logic                         ap_rst_n,
    input  logic                         ctrl_start,
    input  logic [LEN_WIDTH-1:0]         ctrl_length,
    input  logic [NUM_CH-1:0]            ch_mask,
    output logic                         ctrl_busy,
    output logic                         ctrl_done,
    output logic                         ctrl_err,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_CH-1:0]            s_tvalid,
    output logic [NUM_CH-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready
);

    localparam int CH_BITS = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] issued;
    logic [NUM_CH-1:0]    mask_q;
    logic [CH_BITS-1:0]   rr_ptr;

    logic [NUM_CH-1:0]     req;
    logic                  found_lo;
    logic                  found_hi;
    logic [CH_BITS-1:0]    grant_lo;
    logic [CH_BITS-1:0]    grant_hi;
    logic [CH_BITS-1:0]    grant;
    logic [CH_BITS-1:0]    grant_next;
    logic                  load_ok;
    logic                  take;
    logic [LEN_WIDTH-1:0]  issued_inc;
    logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
    logic [DATA_WIDTH-1:0] beat;

    assign req        = s_tvalid & mask_q;
    assign load_ok    = !m_tvalid || m_tready;
    assign take       = (state == RUN) && found_lo && load_ok;
    assign issued_inc = issued + LEN_WIDTH'(1);
    assign ctrl_busy  = (state != IDLE);
    assign grant_next = (grant == CH_BITS'(NUM_CH - 1)) ? '0 : grant + CH_BITS'(1);

    // Two priority searches: lowest requester at or above rr_ptr, else lowest
    // overall (the wrapped case). Descending loop leaves the lowest index last.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch is inferred.
        found_lo = 1'b0;
        found_hi = 1'b0;
        grant_lo = '0;
        grant_hi = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found_lo = 1'b1;
                grant_lo = CH_BITS'(i);
                if (CH_BITS'(i) >= rr_ptr) begin
                    found_hi = 1'b1;
                    grant_hi = CH_BITS'(i);
                end
            end
        end
        grant = found_hi ? grant_hi : grant_lo;
    end

    always_comb begin
        s_tready = '0;
        if (take) begin
            s_tready[grant] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
        beat = ch_data[grant];
        if (TAG_MODE != 0) begin
            beat[DATA_WIDTH-1 -: CH_BITS] = grant;
        end
    end

    always_ff @(posedge ap_aclk) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            issued    <= '0;
            mask_q    <= '0;
            rr_ptr    <= '0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            ctrl_done <= 1'b0;
            ctrl_err  <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register sees pre-edge values.
            ctrl_done <= 1'b0;
            ctrl_err  <= 1'b0;

            // A new load in the same cycle overrides the drop below.
            if (m_tvalid && m_tready) begin
                m_tvalid <= 1'b0;
            end
            if (take) begin
                m_tvalid <= 1'b1;
                m_tdata  <= beat;
                issued   <= issued_inc;
                rr_ptr   <= grant_next;
            end

            case (state)
                IDLE: begin
                    if (ctrl_start) begin
                        len_q  <= ctrl_length;
                        mask_q <= ch_mask;
                        issued <= '0;
                        if (ctrl_length == '0) begin
                            ctrl_done <= 1'b1;
                        end else if (ch_mask == '0) begin
                            ctrl_done <= 1'b1;
                            ctrl_err  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (take && (issued_inc == len_q)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_tvalid && m_tready) begin
                        state     <= IDLE;
                        ctrl_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_krnl_stream_merge_rr.sv
// Bench for krnl_stream_merge_rr: 4 channels, 16-bit beats, tagging on, 8-bit budget.
// A queue-based transaction model predicts every output each cycle.
module tb_krnl_stream_merge_rr;

    logic        ap_aclk = 1'b0;
    logic        ap_rst_n;
    logic        ctrl_start;
    logic [7:0]  ctrl_length;
    logic [3:0]  ch_mask;
    logic        ctrl_busy;
    logic        ctrl_done;
    logic        ctrl_err;
    logic [63:0] s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tready;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;

    krnl_stream_merge_rr #(
        .NUM_CH    (4),
        .DATA_WIDTH(16),
        .LEN_WIDTH (8),
        .TAG_MODE  (1)
    ) dut (
        .ap_aclk    (ap_aclk),
        .ap_rst_n   (ap_rst_n),
        .ctrl_start (ctrl_start),
        .ctrl_length(ctrl_length),
        .ch_mask    (ch_mask),
        .ctrl_busy  (ctrl_busy),
        .ctrl_done  (ctrl_done),
        .ctrl_err   (ctrl_err),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready)
    );

    always #5 ap_aclk = ~ap_aclk;

    typedef struct packed {
        logic [7:0]  len;
        logic [3:0]  mask;
        logic [3:0]  valid_a;
        int          nswitch;
        logic [3:0]  valid_b;
        logic        bp;
        logic        poke;
        int          exp_busy;
        logic        exp_err;
        int          exp_beats;
        logic [15:0] exp_tags;
    } case_t;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a run flag, beats still to accept, pointer and a queue
    // of beats waiting in the output register.
    bit          m_run  = 1'b0;
    int          m_left = 0;
    int          m_ptr  = 0;
    logic [3:0]  m_mask = '0;
    logic [15:0] m_q[$];
    logic        m_done = 1'b0;
    logic        m_err  = 1'b0;

    int          obs_busy;
    int          obs_out;
    int          obs_in;
    logic        obs_done;
    logic        obs_err;
    logic [15:0] obs_tags;

    localparam logic [3:0] BP_PAT = 4'b1001;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack_tags(input int t0, t1, t2, t3, t4, t5, t6, t7);
        return {2'(t7), 2'(t6), 2'(t5), 2'(t4), 2'(t3), 2'(t2), 2'(t1), 2'(t0)};
    endfunction

    task automatic clear_obs();
        obs_busy = 0;
        obs_out  = 0;
        obs_in   = 0;
        obs_done = 1'b0;
        obs_err  = 1'b0;
        obs_tags = '0;
    endtask

    // One clock: check outputs at the falling edge against the model, advance
    // the model with the inputs in force, then step past the rising edge.
    task automatic tick();
        logic [3:0]  er;
        logic [3:0]  rq;
        logic [15:0] d;
        logic [1:0]  gt;
        int          g;
        int          idx;
        bit          out_hs;
        @(negedge ap_aclk);
        er = '0;
        g  = -1;
        rq = s_tvalid & m_mask;
        if (m_run && m_left > 0 && (m_q.size() == 0 || m_tready)) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (g < 0 && ((rq >> idx) & 4'd1) != 4'd0) g = idx;
            end
            if (g >= 0) er = 4'b0001 << g;
        end
        check("s_tready", 32'(s_tready), 32'(er));
        check("m_tvalid", 32'(m_tvalid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("m_tdata", 32'(m_tdata), 32'(m_q[0]));
        check("ctrl_busy", 32'(ctrl_busy), 32'(m_run));
        check("ctrl_done", 32'(ctrl_done), 32'(m_done));
        check("ctrl_err", 32'(ctrl_err), 32'(m_err));

        if (m_tvalid && m_tready) begin
            if (obs_out < 8) obs_tags[2*obs_out +: 2] = m_tdata[15:14];
            obs_out++;
        end
        if ((s_tready & s_tvalid) != '0) obs_in++;
        if (ctrl_busy) obs_busy++;
        if (ctrl_done) begin
            obs_done = 1'b1;
            obs_err  = ctrl_err;
        end

        m_done = 1'b0;
        m_err  = 1'b0;
        if (!ap_rst_n) begin
            m_run  = 1'b0;
            m_left = 0;
            m_ptr  = 0;
            m_q.delete();
        end else if (!m_run) begin
            if (ctrl_start) begin
                if (ctrl_length == 8'd0) begin
                    m_done = 1'b1;
                end else if (ch_mask == 4'd0) begin
                    m_done = 1'b1;
                    m_err  = 1'b1;
                end else begin
                    m_run  = 1'b1;
                    m_left = int'(ctrl_length);
                    m_mask = ch_mask;
                end
            end
        end else begin
            out_hs = (m_q.size() != 0) && m_tready;
            if (out_hs) void'(m_q.pop_front());
            if (g >= 0) begin
                gt = 2'(g);
                d  = 16'(s_tdata >> (g * 16));
                m_q.push_back({gt, d[13:0]});
                m_left--;
                m_ptr = (g + 1) % 4;
            end
            if (m_left == 0 && m_q.size() == 0) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end
        @(posedge ap_aclk);
        #1;
    endtask

    task automatic run_case(input case_t c, input int id);
        int          k;
        logic [15:0] tmask;
        clear_obs();
        ctrl_start  = 1'b1;
        ctrl_length = c.len;
        ch_mask     = c.mask;
        s_tvalid    = c.valid_a;
        m_tready    = 1'b1;
        s_tdata     = {$urandom, $urandom};
        tick();
        ctrl_start = 1'b0;
        k = 0;
        while (!obs_done && k < c.exp_busy + 20) begin
            k++;
            ctrl_length = 8'($urandom);
            ch_mask     = 4'($urandom);
            s_tvalid    = (obs_in < c.nswitch) ? c.valid_a : c.valid_b;
            m_tready    = c.bp ? BP_PAT[(k - 1) % 4] : 1'b1;
            ctrl_start  = c.poke && (k == 2);
            s_tdata     = {$urandom, $urandom};
            tick();
        end
        ctrl_start = 1'b0;
        tmask = (c.exp_beats >= 8) ? 16'hFFFF : 16'((32'd1 << (2 * c.exp_beats)) - 1);
        check($sformatf("case%0d.done_seen", id), 32'(obs_done), 32'd1);
        check($sformatf("case%0d.busy_cycles", id), 32'(obs_busy), 32'(c.exp_busy));
        check($sformatf("case%0d.err", id), 32'(obs_err), 32'(c.exp_err));
        check($sformatf("case%0d.beats", id), 32'(obs_out), 32'(c.exp_beats));
        check($sformatf("case%0d.tags", id), 32'(obs_tags & tmask), 32'(c.exp_tags & tmask));
    endtask

    case_t tbl [8];
    case_t restart;

    initial begin
        int k;
        int len;
        logic [3:0] msk;

        tbl[0] = '{len: 8'd8,   mask: 4'hF, valid_a: 4'hF, nswitch: 999, valid_b: 4'hF, bp: 1'b0, poke: 1'b0,
                   exp_busy: 9,   exp_err: 1'b0, exp_beats: 8,   exp_tags: pack_tags(0, 1, 2, 3, 0, 1, 2, 3)};
        tbl[1] = '{len: 8'd4,   mask: 4'hA, valid_a: 4'hF, nswitch: 999, valid_b: 4'hF, bp: 1'b0, poke: 1'b0,
                   exp_busy: 5,   exp_err: 1'b0, exp_beats: 4,   exp_tags: pack_tags(1, 3, 1, 3, 0, 0, 0, 0)};
        tbl[2] = '{len: 8'd0,   mask: 4'hF, valid_a: 4'hF, nswitch: 999, valid_b: 4'hF, bp: 1'b0, poke: 1'b0,
                   exp_busy: 0,   exp_err: 1'b0, exp_beats: 0,   exp_tags: 16'h0000};
        tbl[3] = '{len: 8'd3,   mask: 4'h0, valid_a: 4'hF, nswitch: 999, valid_b: 4'hF, bp: 1'b0, poke: 1'b0,
                   exp_busy: 0,   exp_err: 1'b1, exp_beats: 0,   exp_tags: 16'h0000};
        tbl[4] = '{len: 8'd5,   mask: 4'hF, valid_a: 4'hF, nswitch: 999, valid_b: 4'hF, bp: 1'b1, poke: 1'b0,
                   exp_busy: 12,  exp_err: 1'b0, exp_beats: 5,   exp_tags: pack_tags(0, 1, 2, 3, 0, 0, 0, 0)};
        tbl[5] = '{len: 8'd5,   mask: 4'hF, valid_a: 4'h4, nswitch: 3,   valid_b: 4'h5, bp: 1'b0, poke: 1'b0,
                   exp_busy: 6,   exp_err: 1'b0, exp_beats: 5,   exp_tags: pack_tags(2, 2, 2, 0, 2, 0, 0, 0)};
        tbl[6] = '{len: 8'd4,   mask: 4'hF, valid_a: 4'hF, nswitch: 999, valid_b: 4'hF, bp: 1'b0, poke: 1'b1,
                   exp_busy: 5,   exp_err: 1'b0, exp_beats: 4,   exp_tags: pack_tags(3, 0, 1, 2, 0, 0, 0, 0)};
        tbl[7] = '{len: 8'd255, mask: 4'hF, valid_a: 4'hF, nswitch: 999, valid_b: 4'hF, bp: 1'b0, poke: 1'b0,
                   exp_busy: 256, exp_err: 1'b0, exp_beats: 255, exp_tags: pack_tags(3, 0, 1, 2, 3, 0, 1, 2)};
        restart = '{len: 8'd2,  mask: 4'hF, valid_a: 4'hF, nswitch: 999, valid_b: 4'hF, bp: 1'b0, poke: 1'b0,
                   exp_busy: 3,   exp_err: 1'b0, exp_beats: 2,   exp_tags: pack_tags(0, 1, 0, 0, 0, 0, 0, 0)};

        // NOTE: inputs change with blocking assignments 1 time unit after the rising edge.
        ap_rst_n    = 1'b0;
        ctrl_start  = 1'b0;
        ctrl_length = '0;
        ch_mask     = '0;
        s_tvalid    = 4'hF;
        s_tdata     = {$urandom, $urandom};
        m_tready    = 1'b1;
        repeat (3) @(posedge ap_aclk);
        #1;
        ap_rst_n = 1'b1;
        @(negedge ap_aclk);
        check("rst.m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst.m_tdata", 32'(m_tdata), 32'd0);
        check("rst.ctrl_busy", 32'(ctrl_busy), 32'd0);
        check("rst.ctrl_done", 32'(ctrl_done), 32'd0);
        check("rst.ctrl_err", 32'(ctrl_err), 32'd0);
        check("rst.s_tready", 32'(s_tready), 32'd0);
        @(posedge ap_aclk);
        #1;

        // Directed table; the order matters because rr_ptr carries across runs.
        for (int i = 0; i < 8; i++) run_case(tbl[i], i);

        // Random runs with random valids and backpressure.
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 24);
            msk = 4'($urandom_range(1, 15));
            clear_obs();
            ctrl_start  = 1'b1;
            ctrl_length = 8'(len);
            ch_mask     = msk;
            s_tvalid    = 4'($urandom);
            m_tready    = 1'b1;
            s_tdata     = {$urandom, $urandom};
            tick();
            ctrl_start = 1'b0;
            k = 0;
            while (!obs_done && k < 400) begin
                k++;
                ctrl_length = 8'($urandom);
                ch_mask     = 4'($urandom);
                s_tvalid    = 4'($urandom);
                m_tready    = ($urandom_range(0, 3) != 0);
                s_tdata     = {$urandom, $urandom};
                tick();
            end
            check($sformatf("rand%0d.done_seen", r), 32'(obs_done), 32'd1);
            check($sformatf("rand%0d.beats", r), 32'(obs_out), 32'(len));
            check($sformatf("rand%0d.err", r), 32'(obs_err), 32'd0);
        end

        // Reset in the middle of a 10-beat run.
        clear_obs();
        ctrl_start  = 1'b1;
        ctrl_length = 8'd10;
        ch_mask     = 4'hF;
        s_tvalid    = 4'hF;
        m_tready    = 1'b1;
        s_tdata     = {$urandom, $urandom};
        tick();
        ctrl_start = 1'b0;
        k = 0;
        while (obs_out < 3 && k < 40) begin
            k++;
            s_tdata = {$urandom, $urandom};
            tick();
        end
        check("midrst.beats_before", 32'(obs_out), 32'd3);
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        @(negedge ap_aclk);
        check("midrst.m_tvalid", 32'(m_tvalid), 32'd0);
        check("midrst.m_tdata", 32'(m_tdata), 32'd0);
        check("midrst.ctrl_busy", 32'(ctrl_busy), 32'd0);
        check("midrst.ctrl_done", 32'(ctrl_done), 32'd0);
        check("midrst.ctrl_err", 32'(ctrl_err), 32'd0);
        check("midrst.s_tready", 32'(s_tready), 32'd0);
        @(posedge ap_aclk);
        #1;
        run_case(restart, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want summary before 500000 time units");
        $fatal(1, "bench watchdog expired");
    end

endmodule
